// File: rtl/coefficient_loader.sv
// Serial coefficient loader: captures LENGTH signed coefficients into a register bank,
// tracks count and running sum, and offers registered random-access readback.
module coefficient_loader #(
  parameter int LENGTH     = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         coefficientValid,
  input  logic signed [DATA_WIDTH-1:0] coefficientIn,
  input  logic [4:0]                   readAddress,
  output logic                         ready,
  output logic                         filterSetFlag,
  output logic [4:0]                   coefficientCount,
  output logic signed [DATA_WIDTH+4:0] coefficientSum,
  output logic signed [DATA_WIDTH-1:0] readData,
  output logic                         overrunFlag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LEN6 = 6'(LENGTH);
  localparam logic [5:0] LAST = 6'(LENGTH - 1);

  state_t                         state_r, state_s;
  logic                           rst_meta_r, rst_sync_r;
  logic                           rst_n_s;
  logic [5:0]                     count_r, count_s;
  logic signed [DATA_WIDTH+4:0]   sum_r, sum_s;
  logic                           overrun_r, overrun_s;
  logic                           ready_r, flag_r;
  logic                           accept_s;
  logic signed [DATA_WIDTH-1:0]   rd_s, rd_r;
  logic signed [DATA_WIDTH-1:0]   bank_r [LENGTH];

  // Assert asynchronously, release two clocks later so the first live edge is clean.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  assign rst_n_s = rst_sync_r;

  // Next-state, counter, sum and overrun decisions.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    sum_s     = sum_r;
    overrun_s = overrun_r;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s   = LOAD;
          count_s   = 6'd0;
          sum_s     = '0;
          overrun_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (!enable) begin
          state_s = IDLE;
          count_s = 6'd0;
        end else if (coefficientValid) begin
          accept_s = 1'b1;
          count_s  = count_r + 6'd1;
          sum_s    = sum_r + {{5{coefficientIn[DATA_WIDTH-1]}}, coefficientIn};
          if (count_r == LAST) begin
            state_s = DONE;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      DONE: begin
        if (!enable) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
          if (coefficientValid) begin
            overrun_s = 1'b1;
          end else begin
            overrun_s = overrun_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r   <= IDLE;
      count_r   <= 6'd0;
      sum_r     <= '0;
      overrun_r <= 1'b0;
      ready_r   <= 1'b0;
      flag_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      sum_r     <= sum_s;
      overrun_r <= overrun_s;
      ready_r   <= (state_s == LOAD);
      flag_r    <= (state_s == DONE);
    end
  end

  // Coefficient bank; reads below see pre-write contents on a same-edge write.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < LENGTH; i++) begin
        bank_r[i] <= '0;
      end
    end else if (accept_s) begin
      bank_r[count_r[4:0]] <= coefficientIn;
    end
  end

  always_comb begin
    rd_s = '0;
    if ({1'b0, readAddress} < LEN6) begin
      rd_s = bank_r[readAddress];
    end else begin
      rd_s = '0;
    end
  end

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rd_r <= '0;
    end else begin
      rd_r <= rd_s;
    end
  end

  assign ready            = ready_r;
  assign filterSetFlag    = flag_r;
  assign coefficientCount = count_r[4:0];
  assign coefficientSum   = sum_r;
  assign readData         = rd_r;
  assign overrunFlag      = overrun_r;

endmodule

// File: doc/coefficient_loader.md
COEFFICIENT_LOADER -- requirements
Module: coefficient_loader

Interface
REQ-001 Parameter LENGTH, default 20, number of filter coefficients, legal range 2..32.
REQ-002 Parameter DATA_WIDTH, default 8, signed coefficient width in bits.
REQ-003 clock  input  1  single system clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; high arms and holds a load session, low aborts or ends it.
REQ-006 coefficientValid  input  1  coefficientIn carries a coefficient this cycle.
REQ-007 coefficientIn  input  DATA_WIDTH  signed serial coefficient, index order 0..LENGTH-1.
REQ-008 readAddress  input  5  coefficient index for readback.
REQ-009 ready  output  1  high only in LOAD; a coefficient is accepted when ready and coefficientValid are both high.
REQ-010 filterSetFlag  output  1  all LENGTH coefficients stored.
REQ-011 coefficientCount  output  5  number of coefficients accepted in the current session.
REQ-012 coefficientSum  output  DATA_WIDTH+5  signed running sum of accepted coefficients.
REQ-013 readData  output  DATA_WIDTH  signed stored coefficient at readAddress.
REQ-014 overrunFlag  output  1  sticky; coefficientValid was seen outside LOAD while enable was high.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and DONE, all registered.
REQ-016 IDLE: when enable is high, the block SHALL go to LOAD on the next edge and clear coefficientCount, coefficientSum and overrunFlag on that edge.
REQ-017 LOAD: each cycle with coefficientValid high, the block SHALL write coefficientIn to bank[coefficientCount], increment coefficientCount, and add the sign-extended coefficientIn to coefficientSum.
REQ-018 LOAD: a cycle with coefficientValid low SHALL change nothing; gaps of any length are legal.
REQ-019 The accepting edge with coefficientCount == LENGTH-1 SHALL move the FSM to DONE, so filterSetFlag is high from the following cycle.
REQ-020 DONE: filterSetFlag SHALL stay high, ready low, and the bank, count and sum frozen.
REQ-021 DONE: coefficientValid high with enable high SHALL set overrunFlag and SHALL NOT write the bank.
REQ-022 DONE: enable low SHALL return the FSM to IDLE, clearing filterSetFlag; the bank contents are kept.
REQ-023 LOAD: enable low SHALL abort to IDLE on the next edge, even with coefficientValid high that cycle (that coefficient is not stored), and SHALL clear coefficientCount.
REQ-024 After an abort, the bank SHALL keep any partially written entries; filterSetFlag SHALL stay low.
REQ-025 Re-asserting enable from IDLE SHALL start a fresh session, overwriting entries from index 0.
REQ-026 readData SHALL be registered with 1-cycle latency from readAddress, in every state.
REQ-027 readAddress >= LENGTH SHALL return 0.
REQ-028 A read of the index being written on the same edge SHALL return the old value.
REQ-029 coefficientSum SHALL never overflow, since LENGTH <= 32 and the sum width is DATA_WIDTH+5.

Reset
REQ-030 On reset low, regardless of clock, the block SHALL force state IDLE, and ready, filterSetFlag, overrunFlag, coefficientCount, coefficientSum and readData to 0, and every bank entry to 0.
REQ-031 Reset asserted mid-LOAD SHALL discard the session; after release the block SHALL wait in IDLE for enable.
REQ-032 Reset release SHALL be synchronised internally so that the first active edge is clean.

Verification
REQ-033 Default parameters, enable high, 20 back-to-back coefficients (34,34,0,49,125,-77,-51,8,98,109,-91,-3,9,1,59,75,19,58,-97,10) -> filterSetFlag high exactly 1 cycle after the 20th accept, coefficientCount=20, coefficientSum=369, readback of indices 0..19 matches the sequence.
REQ-034 Same sequence with coefficientValid low on every other cycle -> identical bank contents and sum; filterSetFlag rises 1 cycle after the 20th valid.
REQ-035 Enable dropped after 7 accepts, then re-raised with 20 new values of 1 -> count returns to 0, final coefficientSum=20, all entries read 1.
REQ-036 Extra coefficientValid in DONE with value 55 -> overrunFlag=1, index 19 still reads 10, coefficientSum still 369.
REQ-037 Reset pulsed low after 12 accepts -> all outputs 0 immediately, readData 0 for every index, ready low until enable is seen.
REQ-038 readAddress=25 in any state -> readData=0 one cycle later.
